dpe_sram_arbiter: RTL and testbench

- Shares the DPE's single-port local SRAM (256 x 32-bit) between three requesters:
  - the scan-chain init/debug loader (scan port);
  - the SPI slave host port (spi port);
  - the instruction core, for fetch, ld and st (core port).
- Sits between those three masters and the SRAM macro.
- Decides one access per cycle, muxes it onto the SRAM and routes read data back with a one-cycle valid pulse.
- Fixed priority for scan, round-robin between spi and core, with starvation promotion.

---
 rtl/dpe_sram_arbiter_if.sv | 50 +++++
 rtl/dpe_sram_arbiter.sv | 117 +++++++++++
 tb/tb_dpe_sram_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dpe_sram_arbiter_if.sv
// dpe_sram_arbiter_if: bundle of the three requester channels (sc, spi, core)
// plus the shared SRAM macro side of the DPE local-memory arbiter.
//   X_req/X_we/X_addr/X_wdata : requester -> arbiter request fields
//   X_gnt/X_rvalid            : arbiter -> requester grant / read-valid
//   rdata                     : shared read data, qualified by X_rvalid
//   sram_*                    : arbiter <-> single-port SRAM macro
// Modports: slave (arbiter), master (requesters), mem (SRAM macro).
interface dpe_sram_arbiter_if #(
  parameter int SRAM_ADDR_WIDTH  = 8,
  parameter int SRAM_WORD_LENGTH = 32
);
  logic                        sc_req,   spi_req,   core_req;
  logic                        sc_we,    spi_we,    core_we;
  logic [SRAM_ADDR_WIDTH-1:0]  sc_addr,  spi_addr,  core_addr;
  logic [SRAM_WORD_LENGTH-1:0] sc_wdata, spi_wdata, core_wdata;
  logic                        sc_gnt,   spi_gnt,   core_gnt;
  logic                        sc_rvalid, spi_rvalid, core_rvalid;
  logic [SRAM_WORD_LENGTH-1:0] rdata;

  logic                        sram_en;
  logic                        sram_we;
  logic [SRAM_ADDR_WIDTH-1:0]  sram_addr;
  logic [SRAM_WORD_LENGTH-1:0] sram_wdata;
  logic [SRAM_WORD_LENGTH-1:0] sram_rdata;

  modport slave (
    input  sc_req, sc_we, sc_addr, sc_wdata,
    input  spi_req, spi_we, spi_addr, spi_wdata,
    input  core_req, core_we, core_addr, core_wdata,
    output sc_gnt, spi_gnt, core_gnt,
    output sc_rvalid, spi_rvalid, core_rvalid,
    output rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output sc_req, sc_we, sc_addr, sc_wdata,
    output spi_req, spi_we, spi_addr, spi_wdata,
    output core_req, core_we, core_addr, core_wdata,
    input  sc_gnt, spi_gnt, core_gnt,
    input  sc_rvalid, spi_rvalid, core_rvalid,
    input  rdata
  );

  modport mem (
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/dpe_sram_arbiter.sv
// dpe_sram_arbiter: shares the DPE single-port local SRAM between the scan
// loader (sc), the SPI host port (spi) and the instruction core (core).
// One access per cycle; grant and SRAM drive are combinational, read data
// returns one cycle later with a one-cycle X_rvalid pulse on the shared rdata.
// Priority: urgent (starved) spi/core > sc > spi/core round-robin.
//   CLK    : system clock, rising edge
//   RESETn : asynchronous active-low reset
//   bus    : requester channels and SRAM side (dpe_sram_arbiter_if.slave)
module dpe_sram_arbiter #(
  parameter int SRAM_ADDR_WIDTH  = 8,
  parameter int SRAM_WORD_LENGTH = 32,
  parameter int STARVE_LIMIT     = 8
) (
  input logic             CLK,
  input logic             RESETn,
  dpe_sram_arbiter_if.slave bus
);

  typedef enum logic {RR_SPI, RR_CORE} rr_e;

  localparam int             CW    = 8;
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  rr_e                         rr_ptr;
  logic [CW-1:0]               starve_spi, starve_core;
  logic                        run_q;
  logic                        urg_spi, urg_core;
  logic                        g_sc, g_spi, g_core;
  logic                        win_we;
  logic [SRAM_ADDR_WIDTH-1:0]  win_addr;
  logic [SRAM_WORD_LENGTH-1:0] win_wdata;

  // run_q is cleared asynchronously and set on the first edge after release,
  // so grants and the SRAM drive are forced low while RESETn is asserted
  // without using the reset pin as a data input.
  always_comb begin
    g_sc     = 1'b0;
    g_spi    = 1'b0;
    g_core   = 1'b0;
    urg_spi  = bus.spi_req  && (starve_spi  == LIMIT);
    urg_core = bus.core_req && (starve_core == LIMIT);
    if (!run_q) begin
    end else if (urg_spi && urg_core) begin
      if (rr_ptr == RR_SPI) g_spi = 1'b1;
      else                  g_core = 1'b1;
    end else if (urg_spi) begin
      g_spi = 1'b1;
    end else if (urg_core) begin
      g_core = 1'b1;
    end else if (bus.sc_req) begin
      g_sc = 1'b1;
    end else if (bus.spi_req && bus.core_req) begin
      if (rr_ptr == RR_SPI) g_spi = 1'b1;
      else                  g_core = 1'b1;
    end else if (bus.spi_req) begin
      g_spi = 1'b1;
    end else if (bus.core_req) begin
      g_core = 1'b1;
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (g_sc) begin
      win_we    = bus.sc_we;
      win_addr  = bus.sc_addr;
      win_wdata = bus.sc_wdata;
    end else if (g_spi) begin
      win_we    = bus.spi_we;
      win_addr  = bus.spi_addr;
      win_wdata = bus.spi_wdata;
    end else if (g_core) begin
      win_we    = bus.core_we;
      win_addr  = bus.core_addr;
      win_wdata = bus.core_wdata;
    end
  end

  assign bus.sc_gnt     = g_sc;
  assign bus.spi_gnt    = g_spi;
  assign bus.core_gnt   = g_core;
  assign bus.sram_en    = g_sc | g_spi | g_core;
  assign bus.sram_we    = win_we;
  assign bus.sram_addr  = win_addr;
  assign bus.sram_wdata = win_wdata;
  assign bus.rdata      = bus.sram_rdata;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      run_q           <= 1'b0;
      rr_ptr          <= RR_SPI;
      starve_spi      <= '0;
      starve_core     <= '0;
      bus.sc_rvalid   <= 1'b0;
      bus.spi_rvalid  <= 1'b0;
      bus.core_rvalid <= 1'b0;
    end else begin
      run_q           <= 1'b1;
      // Read tag: the rvalid registers double as the (winner, read) tag.
      bus.sc_rvalid   <= g_sc   && !bus.sc_we;
      bus.spi_rvalid  <= g_spi  && !bus.spi_we;
      bus.core_rvalid <= g_core && !bus.core_we;

      if (g_spi)       rr_ptr <= RR_CORE;
      else if (g_core) rr_ptr <= RR_SPI;

      if (!bus.spi_req || g_spi)   starve_spi <= '0;
      else if (starve_spi != LIMIT) starve_spi <= starve_spi + 1'b1;

      if (!bus.core_req || g_core)   starve_core <= '0;
      else if (starve_core != LIMIT) starve_core <= starve_core + 1'b1;
    end
  end

endmodule

// File: tb/tb_dpe_sram_arbiter.sv
// tb_dpe_sram_arbiter: table-driven directed bench for dpe_sram_arbiter with
// a behavioural 256x32 single-port SRAM; hand sequences cover withdraw,
// starvation promotion and reset during an outstanding read.
module tb_dpe_sram_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    req_t        sc, spi, core;
    logic [2:0]  gnt;   // {sc, spi, core}
    logic [2:0]  rv;    // {sc, spi, core}
    logic        en, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
  } vec_t;

  localparam req_t R0 = '0;

  logic CLK;
  logic RESETn;
  int   nvec;
  int   nerr;

  dpe_sram_arbiter_if #(.SRAM_ADDR_WIDTH(8), .SRAM_WORD_LENGTH(32)) bus ();

  dpe_sram_arbiter #(
    .SRAM_ADDR_WIDTH(8),
    .SRAM_WORD_LENGTH(32),
    .STARVE_LIMIT(8)
  ) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [0:255];
  logic [31:0] srd;
  always @(posedge CLK) begin
    if (bus.sram_en) begin
      if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
      else             srd <= mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = srd;

  function automatic req_t rd(input logic [7:0] a);
    return '{1'b1, 1'b0, a, 32'h0};
  endfunction

  function automatic req_t wr(input logic [7:0] a, input logic [31:0] d);
    return '{1'b1, 1'b1, a, d};
  endfunction

  function automatic vec_t mkv(input req_t sc, input req_t spi, input req_t core,
                               input logic [2:0] g, input logic [2:0] rv,
                               input logic en, input logic we, input logic [7:0] a,
                               input logic [31:0] wd, input logic [31:0] rdv);
    vec_t v;
    v.sc = sc; v.spi = spi; v.core = core;
    v.gnt = g; v.rv = rv; v.en = en; v.we = we;
    v.addr = a; v.wdata = wd; v.rdata = rdv;
    return v;
  endfunction

  task automatic apply(input req_t sc, input req_t spi, input req_t core);
    bus.sc_req   = sc.req;   bus.sc_we   = sc.we;   bus.sc_addr   = sc.addr;   bus.sc_wdata   = sc.wdata;
    bus.spi_req  = spi.req;  bus.spi_we  = spi.we;  bus.spi_addr  = spi.addr;  bus.spi_wdata  = spi.wdata;
    bus.core_req = core.req; bus.core_we = core.we; bus.core_addr = core.addr; bus.core_wdata = core.wdata;
  endtask

  task automatic chk(input string nm, input logic [2:0] eg, input logic [2:0] erv,
                     input logic een, input logic ewe, input logic [7:0] ea,
                     input logic [31:0] ewd, input logic [31:0] erd);
    logic [2:0] ag, arv;
    ag  = {bus.sc_gnt, bus.spi_gnt, bus.core_gnt};
    arv = {bus.sc_rvalid, bus.spi_rvalid, bus.core_rvalid};
    nvec++;
    if (ag !== eg || arv !== erv || bus.sram_en !== een || bus.sram_we !== ewe ||
        bus.sram_addr !== ea || bus.sram_wdata !== ewd ||
        (erv != 3'b000 && bus.rdata !== erd)) begin
      nerr++;
      $display("FAIL %s: got gnt=%b rv=%b en=%b we=%b addr=%h wdata=%h rdata=%h ; want gnt=%b rv=%b en=%b we=%b addr=%h wdata=%h rdata=%h",
               nm, ag, arv, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata, bus.rdata,
               eg, erv, een, ewe, ea, ewd, erd);
    end
  endtask

  task automatic step(input string nm, input req_t sc, input req_t spi, input req_t core,
                      input logic [2:0] eg, input logic [2:0] erv,
                      input logic een, input logic ewe, input logic [7:0] ea,
                      input logic [31:0] ewd, input logic [31:0] erd);
    @(negedge CLK);
    apply(sc, spi, core);
    #1;
    chk(nm, eg, erv, een, ewe, ea, ewd, erd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  vec_t vq[$];
  req_t W30, S21, C20;

  initial begin
    nvec = 0;
    nerr = 0;
    RESETn = 1'b0;
    apply(R0, R0, R0);
    W30 = wr(8'h30, 32'hA5A5A5A5);
    S21 = rd(8'h21);
    C20 = rd(8'h20);

    vq.push_back(mkv(R0, R0, R0,                               3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0));
    vq.push_back(mkv(R0, wr(8'h20, 32'h000000FF), R0,          3'b010, 3'b000, 1, 1, 8'h20, 32'hFF, 32'h0));
    vq.push_back(mkv(R0, R0, rd(8'h20),                        3'b001, 3'b000, 1, 0, 8'h20, 32'h0, 32'h0));
    vq.push_back(mkv(R0, R0, R0,                               3'b000, 3'b001, 0, 0, 8'h00, 32'h0, 32'hFF));
    vq.push_back(mkv(wr(8'h21, 32'h03020100), R0, rd(8'h21),   3'b100, 3'b000, 1, 1, 8'h21, 32'h03020100, 32'h0));
    vq.push_back(mkv(R0, R0, rd(8'h21),                        3'b001, 3'b000, 1, 0, 8'h21, 32'h0, 32'h0));
    vq.push_back(mkv(R0, R0, R0,                               3'b000, 3'b001, 0, 0, 8'h00, 32'h0, 32'h03020100));
    vq.push_back(mkv(R0, S21, C20,                             3'b010, 3'b000, 1, 0, 8'h21, 32'h0, 32'h0));
    vq.push_back(mkv(R0, S21, C20,                             3'b001, 3'b010, 1, 0, 8'h20, 32'h0, 32'h03020100));
    vq.push_back(mkv(R0, S21, C20,                             3'b010, 3'b001, 1, 0, 8'h21, 32'h0, 32'hFF));
    vq.push_back(mkv(R0, S21, C20,                             3'b001, 3'b010, 1, 0, 8'h20, 32'h0, 32'h03020100));
    vq.push_back(mkv(R0, S21, C20,                             3'b010, 3'b001, 1, 0, 8'h21, 32'h0, 32'hFF));
    vq.push_back(mkv(R0, S21, C20,                             3'b001, 3'b010, 1, 0, 8'h20, 32'h0, 32'h03020100));
    vq.push_back(mkv(R0, R0, R0,                               3'b000, 3'b001, 0, 0, 8'h00, 32'h0, 32'hFF));
    vq.push_back(mkv(R0, R0, C20,                              3'b001, 3'b000, 1, 0, 8'h20, 32'h0, 32'h0));
    vq.push_back(mkv(R0, R0, R0,                               3'b000, 3'b001, 0, 0, 8'h00, 32'h0, 32'hFF));

    repeat (3) @(negedge CLK);
    #1;
    chk("reset_state", 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].sc, vq[i].spi, vq[i].core,
           vq[i].gnt, vq[i].rv, vq[i].en, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].rdata);
    end

    // spi waits behind sc for 3 cycles then withdraws; its counter must clear,
    // so a fresh request waits the full 8 cycles before promotion.
    for (int i = 0; i < 3; i++)
      step($sformatf("withdraw_wait%0d", i), W30, S21, R0, 3'b100, 3'b000, 1, 1, 8'h30, 32'hA5A5A5A5, 32'h0);
    step("withdraw_drop", W30, R0, R0, 3'b100, 3'b000, 1, 1, 8'h30, 32'hA5A5A5A5, 32'h0);
    for (int i = 0; i < 8; i++)
      step($sformatf("spi_rewait%0d", i), W30, S21, R0, 3'b100, 3'b000, 1, 1, 8'h30, 32'hA5A5A5A5, 32'h0);
    step("spi_urgent", W30, S21, R0, 3'b010, 3'b000, 1, 0, 8'h21, 32'h0, 32'h0);
    step("spi_urgent_rv", W30, R0, R0, 3'b100, 3'b010, 1, 1, 8'h30, 32'hA5A5A5A5, 32'h03020100);
    step("all_idle", R0, R0, R0, 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);

    // Core starvation under continuous sc traffic, twice in a row.
    for (int i = 0; i < 8; i++)
      step($sformatf("core_starve%0d", i), W30, R0, C20, 3'b100, 3'b000, 1, 1, 8'h30, 32'hA5A5A5A5, 32'h0);
    step("core_urgent", W30, R0, C20, 3'b001, 3'b000, 1, 0, 8'h20, 32'h0, 32'h0);
    step("core_urgent_rv", W30, R0, C20, 3'b100, 3'b001, 1, 1, 8'h30, 32'hA5A5A5A5, 32'hFF);
    for (int i = 0; i < 7; i++)
      step($sformatf("core_restarve%0d", i), W30, R0, C20, 3'b100, 3'b000, 1, 1, 8'h30, 32'hA5A5A5A5, 32'h0);
    step("core_urgent2", W30, R0, C20, 3'b001, 3'b000, 1, 0, 8'h20, 32'h0, 32'h0);
    step("core_urgent2_rv", R0, R0, R0, 3'b000, 3'b001, 0, 0, 8'h00, 32'h0, 32'hFF);

    // Leave rr_ptr at core, then reset with a core read in flight.
    step("pre_rst_spi", R0, S21, R0, 3'b010, 3'b000, 1, 0, 8'h21, 32'h0, 32'h0);
    @(negedge CLK);
    apply(R0, R0, C20);
    #1;
    chk("rst_core_gnt", 3'b001, 3'b010, 1, 0, 8'h20, 32'h0, 32'h03020100);
    #1;
    RESETn = 1'b0;
    #1;
    chk("in_reset_0", 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("in_reset_%0d", i), 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    apply(R0, R0, R0);
    #1;
    chk("post_rst_0", 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);
    step("post_rst_1", R0, R0, R0, 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);
    step("post_rst_2", R0, R0, R0, 3'b000, 3'b000, 0, 0, 8'h00, 32'h0, 32'h0);
    step("post_rst_rr", R0, S21, C20, 3'b010, 3'b000, 1, 0, 8'h21, 32'h0, 32'h0);
    step("post_rst_rv", R0, R0, R0, 3'b000, 3'b010, 0, 0, 8'h00, 32'h0, 32'h03020100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
